// File: rtl/toggle_event_decoder.sv
// Toggle-event decoder: synchronizes a toggle line and queues one event per level change, released over valid/ready.
// Optional macro TOGGLE_GLITCH_FILTER_EN adds a two-sample level filter after the synchronizer.
module toggle_event_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int TOTAL_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tog_in,
   input  logic               evt_ready,
   input  logic               clr_ovf,
   output logic               evt_valid,
   output logic [CNT_W-1:0]   pending,
   output logic [TOTAL_W-1:0] total,
   output logic               overflow,
   output logic               busy
);

   typedef enum logic [1:0] {FILL, PRIME, RUN} state_t;

`ifdef TOGGLE_GLITCH_FILTER_EN
   localparam int FILL_CYCLES = SYNC_STAGES + 1;
`else
   localparam int FILL_CYCLES = SYNC_STAGES;
`endif
   localparam logic [2:0]       FILL_LAST = 3'(FILL_CYCLES - 1);
   localparam logic [CNT_W-1:0] PEND_MAX  = '1;

   state_t                 state;
   state_t                 state_next;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic [2:0]             fill_cnt;
   logic                   sync_out;
   logic                   level;
   logic                   prev;
   logic                   tog_edge;
   logic                   accept;
   logic                   drop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_chain <= '0;
      else        sync_chain <= {sync_chain[SYNC_STAGES-2:0], tog_in};
   end

   assign sync_out = sync_chain[SYNC_STAGES-1];

`ifdef TOGGLE_GLITCH_FILTER_EN
   logic sync_last;
   logic filt_hold;

   // A new level passes only once two consecutive synchronized samples agree on it.
   assign level = (sync_out == sync_last) ? sync_out : filt_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_last <= 1'b0;
         filt_hold <= 1'b0;
      end else begin
         sync_last <= sync_out;
         filt_hold <= level;
      end
   end
`else
   assign level = sync_out;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      case (state)
         FILL:    if (fill_cnt == FILL_LAST) state_next = PRIME;
         PRIME:   state_next = RUN;
         RUN:     busy = 1'b0;
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                       fill_cnt <= '0;
      else if (state == FILL && fill_cnt != FILL_LAST)  fill_cnt <= fill_cnt + 3'd1;
   end

   // prev is loaded in PRIME so whatever level tog_in holds at release never counts as an event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              prev <= 1'b0;
      else if (state != FILL)  prev <= level;
   end

   assign tog_edge  = (state == RUN) && (level != prev);
   assign evt_valid = (pending != '0);
   assign accept    = evt_valid && evt_ready;
   assign drop      = tog_edge && !accept && (pending == PEND_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending  <= '0;
         total    <= '0;
         overflow <= 1'b0;
      end else begin
         if (tog_edge && !accept && !drop) pending <= pending + CNT_W'(1);
         else if (!tog_edge && accept)     pending <= pending - CNT_W'(1);
         if (tog_edge && !drop)            total <= total + TOTAL_W'(1);
         if (drop)                         overflow <= 1'b1;
         else if (clr_ovf)                 overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: directed scenarios plus randomized toggling, checked every cycle
// against a model that schedules each toggle's arrival time and counts events arithmetically.
module tb_toggle_event_decoder;

   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 4;
   localparam int TOTAL_W     = 16;
`ifdef TOGGLE_GLITCH_FILTER_EN
   localparam int LAT = SYNC_STAGES + 1;
`else
   localparam int LAT = SYNC_STAGES;
`endif
   localparam int BUSY_CYC  = LAT + 1;
   localparam int PEND_MAX  = (1 << CNT_W) - 1;
   localparam int TOTAL_MOD = 1 << TOTAL_W;

   logic               clk;
   logic               reset;
   logic               tog_in;
   logic               evt_ready;
   logic               clr_ovf;
   logic               evt_valid;
   logic [CNT_W-1:0]   pending;
   logic [TOTAL_W-1:0] total;
   logic               overflow;
   logic               busy;

   int    cyc;
   int    rel_cyc;
   int    checks;
   int    errors;
   int    m_pend;
   int    m_total;
   bit    m_ovf;
   int    due_q[$];
   string phase;

   toggle_event_decoder #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W(CNT_W),
      .TOTAL_W(TOTAL_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tog_in(tog_in),
      .evt_ready(evt_ready),
      .clr_ovf(clr_ovf),
      .evt_valid(evt_valid),
      .pending(pending),
      .total(total),
      .overflow(overflow),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge of the event model: an arriving event plus a possible acceptance.
   task automatic modelEdge(input bit rdy, input bit clr);
      bit ev;
      bit acc;
      bit dropped;
      ev = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
         ev = 1'b1;
         void'(due_q.pop_front());
      end
      acc     = rdy && (m_pend > 0);
      dropped = ev && !acc && (m_pend == PEND_MAX);
      if (dropped)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (ev && !dropped) m_total = (m_total + 1) % TOTAL_MOD;
      m_pend = m_pend + ((ev && !dropped) ? 1 : 0) - (acc ? 1 : 0);
   endtask

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      bit exp_busy;
      exp_busy = (reset === 1'b0) || ((cyc - rel_cyc) < BUSY_CYC);
      checkValue({tag, ".pending"},   32'(pending),   32'(m_pend));
      checkValue({tag, ".evt_valid"}, 32'(evt_valid), 32'(m_pend != 0));
      checkValue({tag, ".total"},     32'(total),     32'(m_total));
      checkValue({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
      checkValue({tag, ".busy"},      32'(busy),      32'(exp_busy));
   endtask

   // Drive inputs for one cycle; counted toggles are scheduled to surface LAT edges after the next edge.
   task automatic applyStimulus(input bit flip, input bit counted, input bit rdy, input bit clr);
      if (flip) begin
         tog_in = ~tog_in;
         if (counted) due_q.push_back(cyc + 1 + LAT);
      end
      evt_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      cyc++;
      if (reset === 1'b1) modelEdge(rdy, clr);
      #1;
      checkOutput(phase);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, rdy, 1'b0);
   endtask

   task automatic toggles(input int n, input bit rdy);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 1'b1, rdy, 1'b0);
         idle(3, rdy);
      end
   endtask

   task automatic doReset();
      reset = 1'b0;
      due_q.delete();
      m_pend  = 0;
      m_total = 0;
      m_ovf   = 1'b0;
      #1;
      checkOutput("async_reset");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset   = 1'b1;
      rel_cyc = cyc;
   endtask

   initial begin
      int gap;
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      rel_cyc   = 0;
      m_pend    = 0;
      m_total   = 0;
      m_ovf     = 1'b0;
      reset     = 1'b0;
      tog_in    = 1'b1;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;

      phase = "reset_hold";
      #2;
      checkOutput(phase);
      idle(2, 1'b0);
      reset   = 1'b1;
      rel_cyc = cyc;
      $display("[TB] reset released with tog_in=1");
      phase = "fill_prime";
      idle(10, 1'b1);

      phase = "burst5";
      toggles(5, 1'b0);
      idle(4, 1'b0);
      checkValue("burst5.count", 32'(pending), 32'd5);
      phase = "drain5";
      idle(5, 1'b1);
      checkValue("drain5.valid", 32'(evt_valid), 32'd0);

      phase = "saturate";
      toggles(17, 1'b0);
      idle(4, 1'b0);
      checkValue("saturate.count", 32'(pending), 32'd15);
      checkValue("saturate.ovf", 32'(overflow), 32'd1);
      phase = "clr_ovf";
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkValue("clr_ovf.count", 32'(pending), 32'd15);
      phase = "drain15";
      idle(16, 1'b1);

      phase = "stream_ready";
      toggles(8, 1'b1);
      idle(4, 1'b1);
      phase = "coincide";
      toggles(4, 1'b0);
      idle(4, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      idle(8, 1'b1);

      phase = "midstream_reset";
      toggles(3, 1'b0);
      idle(4, 1'b0);
      checkValue("midstream.count", 32'(pending), 32'd3);
      doReset();
      phase = "toggle_in_fill";
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      idle(12, 1'b1);

`ifdef TOGGLE_GLITCH_FILTER_EN
      phase = "glitch";
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idle(8, 1'b0);
      phase = "filtered_edge";
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idle(8, 1'b0);
      idle(2, 1'b1);
`endif

      phase = "random";
      gap   = 0;
      for (int i = 0; i < 600; i++) begin
         bit rdy;
         bit clr;
         rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         if (gap == 0) begin
            applyStimulus(1'b1, 1'b1, rdy, clr);
            gap = $urandom_range(2, 5);
         end else begin
            applyStimulus(1'b0, 1'b0, rdy, clr);
            gap--;
         end
      end
      idle(20, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receive end of toggle-encoded event signalling. A T flip-flop on the far side flips tog_in once per event. This block synchronizes tog_in into clk and detects each transition.
- Each detected transition is queued as a pending event. Events are released over a valid/ready handshake.
- Also keeps a running total of accepted events and a sticky overflow flag. Sits between any toggle-output source (T_FF based divider or flag) and a synchronous consumer.

Parameters:
SYNC_STAGES, 2, flops in tog_in synchronizer chain (legal 2..4)
CNT_W, 4, width of pending-event counter; max pending = 2^CNT_W-1
TOTAL_W, 16, width of total accepted-event counter (wraps)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tog_in  input  1  asynchronous toggle line; every level change = one event
evt_ready  input  1  consumer accepts one event when evt_valid & evt_ready
clr_ovf  input  1  synchronous clear of overflow flag
evt_valid  output  1  at least one event pending
pending  output  CNT_W  number of pending events
total  output  TOTAL_W  accepted-event count, modulo 2^TOTAL_W
overflow  output  1  sticky: an event was dropped because pending was saturated
busy  output  1  high while not in RUN state

Behaviour:
- Reset (reset=0, async) sets the following:
  - sync chain = 0, prev = 0, pending = 0, total = 0, overflow = 0
  - evt_valid = 0, busy = 1, state = FILL, fill counter = 0
- State FILL:
  - Counts SYNC_STAGES clocks after reset release so the chain holds real samples.
  - No edge detection in this state.
  - When the counter reaches SYNC_STAGES-1, go to PRIME.
- State PRIME (1 cycle):
  - prev <= synchronized level; no event generated, whatever the level of tog_in at reset release.
  - Next state is RUN.
- State RUN:
  - edge = sync_out XOR prev; prev <= sync_out every cycle.
  - busy = 0.
- Latency: a tog_in change meeting setup before edge k gives evt_valid = 1 after edge k+SYNC_STAGES (k+2 at default).
- Pending counter update per cycle (acc = evt_valid & evt_ready):
  - edge & !acc: pending+1; total+1.
  - !edge & acc: pending-1.
  - edge & acc: pending unchanged; total+1.
  - edge & !acc & pending == max: pending stays at max; event dropped; total not incremented; overflow <= 1.
- evt_valid = (pending != 0). Combinational from the register, so no cycle of delay.
- evt_ready while evt_valid = 0 is ignored; pending never underflows.
- total wraps from 2^TOTAL_W-1 to 0 without affecting overflow.
- overflow: set has priority over clr_ovf in the same cycle.
- Toggles faster than one per clk after synchronization are indistinguishable and may be lost. The source must hold each level ≥ 2 clk periods (≥ 3 with the optional filter).
- Reset mid-operation: all state is discarded immediately, and the block re-enters FILL on release.

Optional Feature:
Macro TOGGLE_GLITCH_FILTER_EN.
- Defined:
  - Adds one stage after the synchronizer. The filtered level updates only when sync_out has held the same value for 2 consecutive cycles.
  - Edge detection and PRIME use the filtered level.
  - Latency becomes SYNC_STAGES+1 cycles.
  - A level lasting exactly 1 clk is ignored.
- Undefined:
  - Unfiltered sync_out is used; behaviour exactly as above.

Test Plan:
1. Reset with tog_in=1 held, release, wait 10 clks -> evt_valid=0, pending=0, total=0, busy falls to 0 after SYNC_STAGES+1 clks.
2. evt_ready=0; toggle tog_in 5 times, 4 clks apart -> pending=5, total=5, evt_valid=1. Then evt_ready=1 -> pending counts down 4,3,2,1,0 on consecutive clks; evt_valid low after the 5th acceptance.
3. evt_ready=0; 17 toggles with CNT_W=4 -> pending=15, total=15, overflow=1. Pulse clr_ovf -> overflow=0 and pending stays 15.
4. evt_ready=1 held; toggle tog_in every 4 clks, 8 times -> each event shows a single-cycle evt_valid; pending never exceeds 1; total=8. Include a case where edge and acceptance coincide: pending unchanged, total still incremented.
5. Assert reset for 1 clk mid-stream with pending=3 -> all outputs return to reset values asynchronously. Toggles during FILL/PRIME produce no event.
6. With TOGGLE_GLITCH_FILTER_EN: 1-clk glitch on tog_in -> total unchanged. A 3-clk level change -> total+1 and latency 3 clks at SYNC_STAGES=2.
